// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Slot destinations are stored at a fixed width so one struct serves every REG_W up to SLOT_DST_W.
package hazard_pkg;

  localparam int REG_W_DEF      = 3;
  localparam int PIPE_DEPTH_DEF = 3;
  localparam int CNT_W_DEF      = 16;

  // Widest register index a slot can hold; REG_W must not exceed this.
  localparam int SLOT_DST_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_DST_W-1:0] dst;
    logic                  is_load;
  } haz_slot_t;

  function automatic int pend_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/haz_slot_match.sv
// Dual-source compare of one in-flight write slot against the decode operands.
// ENABLE/LOAD_ONLY let the parent restrict which slots may raise a hazard.
module haz_slot_match
  import hazard_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter bit ENABLE    = 1'b1,
  parameter bit LOAD_ONLY = 1'b0
) (
  input  haz_slot_t        slot_i,
  input  logic [REG_W-1:0] src_a_i,
  input  logic [REG_W-1:0] src_b_i,
  input  logic             src_a_used_i,
  input  logic             src_b_used_i,
  output logic             match_a_o,
  output logic             match_b_o
);

  logic qualify;

  // A slot can only stall decode when this stage is allowed to, and in
  // load-only mode when the producer is a load that forwarding cannot cover.
  assign qualify = ENABLE & slot_i.valid & (LOAD_ONLY ? slot_i.is_load : 1'b1);

  assign match_a_o = qualify & src_a_used_i & (slot_i.dst == SLOT_DST_W'(src_a_i));
  assign match_b_o = qualify & src_b_used_i & (slot_i.dst == SLOT_DST_W'(src_b_i));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard unit: shadow pipeline of in-flight writes, NOP request, stall counter.
// Optional macro HAZ_FWD_EN: forwarding exists, so only a load in execute (slot 0) stalls decode.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int  REG_W      = REG_W_DEF,
  parameter int  PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int  CNT_W      = CNT_W_DEF,
  localparam int PEND_W     = pend_w(PIPE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_src_a,
  input  logic [REG_W-1:0]  id_src_b,
  input  logic              id_src_a_used,
  input  logic              id_src_b_used,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              fetch_stall,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              send_nop_n,
  output logic [1:0]        hazard_src,
  output logic [PEND_W-1:0] pend_count,
  output logic [CNT_W-1:0]  stall_count
);

  haz_slot_t [PIPE_DEPTH-1:0] slot_q, slot_d;
  logic      [PEND_W-1:0]     pend_q, pend_d;
  logic      [CNT_W-1:0]      stall_q, stall_d;

  logic [PIPE_DEPTH-1:0] match_a, match_b;
  logic                  hazard;
  logic                  issue;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_slot
`ifdef HAZ_FWD_EN
    localparam bit SLOT_EN   = (k == 0);
    localparam bit SLOT_LOAD = 1'b1;
`else
    localparam bit SLOT_EN   = 1'b1;
    localparam bit SLOT_LOAD = 1'b0;
`endif
    haz_slot_match #(
      .REG_W    (REG_W),
      .ENABLE   (SLOT_EN),
      .LOAD_ONLY(SLOT_LOAD)
    ) u_match (
      .slot_i      (slot_q[k]),
      .src_a_i     (id_src_a),
      .src_b_i     (id_src_b),
      .src_a_used_i(id_src_a_used),
      .src_b_used_i(id_src_b_used),
      .match_a_o   (match_a[k]),
      .match_b_o   (match_b[k])
    );
  end

  assign hazard_src = {|match_b, |match_a};
  assign hazard     = id_valid & (|hazard_src);
  assign send_nop_n = ~(hazard | fetch_stall | mem_stall);

  // Only a real, writing instruction that actually leaves decode occupies a slot.
  assign issue = send_nop_n & id_valid & id_wr_en & ~flush;

  // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    slot_d  = slot_q;
    pend_d  = pend_q;
    stall_d = stall_q;

    // A data-cache stall freezes the whole shadow pipeline, flush included.
    if (!mem_stall) begin
      for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
        slot_d[k] = slot_q[k-1];
      end
      slot_d[0] = '0;
      if (issue) begin
        slot_d[0].valid   = 1'b1;
        slot_d[0].dst     = SLOT_DST_W'(id_dst);
        slot_d[0].is_load = id_is_load;
      end
      pend_d = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        pend_d = pend_d + PEND_W'(slot_d[k].valid);
      end
    end

    if (!send_nop_n && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      pend_q  <= '0;
      stall_q <= '0;
    end else begin
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
    end
  end

  assign pend_count  = pend_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic against a queue model.
module tb_hazard_scoreboard;

  localparam int REG_W  = 3;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;
  localparam int PEND_W = $clog2(DEPTH + 1);

`ifdef HAZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_src_a_used, id_src_b_used, id_wr_en, id_is_load;
  logic [REG_W-1:0] id_src_a, id_src_b, id_dst;
  logic             fetch_stall, mem_stall, flush;

  logic              send_nop_n, s_send_nop_n;
  logic [1:0]        hazard_src, s_hazard_src;
  logic [PEND_W-1:0] pend_count, s_pend_count;
  logic [CNT_W-1:0]  stall_count;
  logic [SAT_W-1:0]  s_stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(REG_W), .PIPE_DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .fetch_stall(fetch_stall), .mem_stall(mem_stall), .flush(flush),
    .send_nop_n(send_nop_n), .hazard_src(hazard_src),
    .pend_count(pend_count), .stall_count(stall_count)
  );

  hazard_scoreboard #(.REG_W(REG_W), .PIPE_DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
    .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .fetch_stall(fetch_stall), .mem_stall(mem_stall), .flush(flush),
    .send_nop_n(s_send_nop_n), .hazard_src(s_hazard_src),
    .pend_count(s_pend_count), .stall_count(s_stall_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight writes as a list, youngest first.
  typedef struct {
    bit valid;
    int dst;
    bit ld;
  } ent_t;

  ent_t pipe[$];
  int   m_stall, m_stall_sat;
  bit   obs_nop_n;

  function automatic bit src_hit(input int src, input bit used);
    bit hit = 1'b0;
    for (int k = 0; k < pipe.size(); k++) begin
      if (pipe[k].valid && used && pipe[k].dst == src) begin
        if (!FWD || (k == 0 && pipe[k].ld)) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  task automatic model_reset();
    ent_t e = '{valid: 1'b0, dst: 0, ld: 1'b0};
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back(e);
    m_stall     = 0;
    m_stall_sat = 0;
  endtask

  // One clock: compare everything just before the edge, then advance the model.
  task automatic cycle();
    bit   ha, hb, exp_nop_n;
    int   pend;
    ent_t e;
    #1;
    ha = src_hit(int'(id_src_a), id_src_a_used);
    hb = src_hit(int'(id_src_b), id_src_b_used);
    exp_nop_n = !((id_valid && (ha || hb)) || fetch_stall || mem_stall);
    pend = 0;
    foreach (pipe[k]) if (pipe[k].valid) pend++;
    check("send_nop_n", send_nop_n, exp_nop_n);
    check("hazard_src", hazard_src, {hb, ha});
    check("pend_count", pend_count, pend);
    check("stall_count", stall_count, m_stall);
    check("sat_send_nop_n", s_send_nop_n, exp_nop_n);
    check("sat_stall_count", s_stall_count, m_stall_sat);
    obs_nop_n = send_nop_n;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!exp_nop_n) begin
        if (m_stall < (1 << CNT_W) - 1) m_stall++;
        if (m_stall_sat < (1 << SAT_W) - 1) m_stall_sat++;
      end
      if (!mem_stall) begin
        e = '{valid: 1'b0, dst: 0, ld: 1'b0};
        if (exp_nop_n && id_valid && id_wr_en && !flush)
          e = '{valid: 1'b1, dst: int'(id_dst), ld: id_is_load};
        pipe.push_front(e);
        void'(pipe.pop_back());
      end
    end
    @(negedge clk);
  endtask

  task automatic set_instr(input bit v, input int a, input bit au, input int b, input bit bu,
                           input int d, input bit wr, input bit ld);
    id_valid      = v;
    id_src_a      = REG_W'(a);
    id_src_a_used = au;
    id_src_b      = REG_W'(b);
    id_src_b_used = bu;
    id_dst        = REG_W'(d);
    id_wr_en      = wr;
    id_is_load    = ld;
  endtask

  task automatic idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    fetch_stall = 0;
    mem_stall   = 0;
    flush       = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  // Hold the current decode instruction until it issues; count stall cycles.
  task automatic issue_and_count(input string tag, input int exp_stalls);
    int n    = 0;
    bit done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      cycle();
      if (obs_nop_n) done = 1'b1;
      else n++;
    end
    check({tag, "_issued"}, done, 1);
    check({tag, "_stalls"}, n, exp_stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;

    // Reset then idle.
    do_reset();
    cycle();
    check("reset_nop_n", obs_nop_n, 1);
    check("reset_pend", pend_count, 0);
    check("reset_stall", stall_count, 0);

    // Write R3, then read R3 as src A.
    do_reset();
    set_instr(1, 0, 0, 0, 0, 3, 1, 0);
    cycle();
    set_instr(1, 3, 1, 1, 0, 0, 0, 0);
    #1 check("raw_hazard_src", hazard_src, FWD ? 2'b00 : 2'b01);
    issue_and_count("raw_r3", FWD ? 0 : DEPTH);
    idle();
    check("raw_stall_count", stall_count, FWD ? 0 : DEPTH);

    // Write R3, then mem_stall for 4 cycles on a reader of R5.
    do_reset();
    set_instr(1, 0, 0, 0, 0, 3, 1, 0);
    cycle();
    set_instr(1, 5, 1, 0, 0, 0, 0, 0);
    mem_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("frozen_pend", pend_count, 1);
      check("frozen_hazard_src", hazard_src, 0);
      cycle();
    end
    idle();
    check("frozen_stall_count", stall_count, 4);
    check("frozen_pend_after", pend_count, 1);

    // Hazard on R2 with flush in the same cycle.
    do_reset();
    set_instr(1, 0, 0, 0, 0, 2, 1, 0);
    cycle();
    set_instr(1, 2, 1, 0, 0, 6, 1, 0);
    flush = 1;
    #1 check("flush_nop_n", send_nop_n, FWD ? 1 : 0);
    cycle();
    idle();
    check("flush_pend", pend_count, 1);
    check("flush_stall_count", stall_count, FWD ? 0 : 1);

    // Load to R4, then a reader of R4 on src B.
    do_reset();
    set_instr(1, 0, 0, 0, 0, 4, 1, 1);
    cycle();
    set_instr(1, 0, 0, 4, 1, 1, 1, 0);
    #1 check("load_hazard_src", hazard_src, 2'b10);
    issue_and_count("load_use", FWD ? 1 : DEPTH);

    // ALU write to R4, then a reader of R4.
    do_reset();
    set_instr(1, 0, 0, 0, 0, 4, 1, 0);
    cycle();
    set_instr(1, 4, 1, 4, 1, 0, 0, 0);
    issue_and_count("alu_use", FWD ? 0 : DEPTH);

    // Counter saturation: 2**SAT_W + 5 fetch-stall cycles.
    do_reset();
    fetch_stall = 1;
    for (int i = 0; i < (1 << SAT_W) + 5; i++) cycle();
    idle();
    check("sat_count", s_stall_count, (1 << SAT_W) - 1);
    check("wide_count", stall_count, (1 << SAT_W) + 5);

    // Reset in the middle of a stall clears every hazard.
    do_reset();
    set_instr(1, 0, 0, 0, 0, 1, 1, 1);
    cycle();
    set_instr(1, 1, 1, 0, 0, 0, 0, 0);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1 check("post_reset_nop_n", send_nop_n, 1);
    check("post_reset_pend", pend_count, 0);
    cycle();

    // Random traffic.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(63) == 0);
      id_valid    = ($urandom_range(3) != 0);
      id_src_a    = REG_W'($urandom);
      id_src_b    = REG_W'($urandom);
      id_src_a_used = $urandom_range(1);
      id_src_b_used = $urandom_range(1);
      id_dst      = REG_W'($urandom);
      id_wr_en    = ($urandom_range(2) != 0);
      id_is_load  = ($urandom_range(2) == 0);
      fetch_stall = ($urandom_range(7) == 0);
      mem_stall   = ($urandom_range(7) == 0);
      flush       = ($urandom_range(9) == 0);
      cycle();
    end
    rst = 0;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised decode-stage hazard unit for the pipelined processor. It tracks in-flight register writes in a PIPE_DEPTH-slot shadow pipeline and compares each decoded instruction's source registers against them. It requests a NOP whenever a RAW hazard exists or a fetch or memory cache stall is active, and counts stall cycles for performance analysis. It sits beside the decode stage, drives the decode/execute bubble insert, and replaces the fixed three-stage comparator.

## Interface
- REG_W, 3, register-index width (2**REG_W architectural registers)
- PIPE_DEPTH, 3, number of tracked stages after decode (slot 0 = execute … slot PIPE_DEPTH-1 = writeback)
- CNT_W, 16, stall-counter width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction (low = NOP/bubble)
- id_src_a, id_src_b  in  REG_W each  source register indices
- id_src_a_used, id_src_b_used  in  1 each  source is actually read
- id_dst  in  REG_W  destination register
- id_wr_en  in  1  instruction writes id_dst
- id_is_load  in  1  instruction is a memory load
- fetch_stall, mem_stall  in  1 each  instruction/data cache stall
- flush  in  1  squash the instruction entering execute (branch redirect)
- send_nop_n  out  1  low = insert NOP into execute and hold fetch/decode
- hazard_src  out  2  bit0 = src A hazard, bit1 = src B hazard (combinational)
- pend_count  out  $clog2(PIPE_DEPTH+1)  number of valid slots
- stall_count  out  CNT_W  saturating count of cycles with send_nop_n low

## Operation
- Each slot holds {valid, dst, is_load}. Only instructions with id_wr_en=1 make a slot valid.
- Match: slot k matches src X if slot.valid & X_used & slot.dst==X. All slots are compared, including writeback; there is no register-file bypass.
- hazard = id_valid & any match (default build). hazard_src reports per-source OR over slots.
- send_nop_n = ~(hazard | fetch_stall | mem_stall).
- Slot advance (when mem_stall=0): slot k+1 <= slot k, and the writeback entry retires.
  - Slot 0 loads the decode instruction if send_nop_n=1, id_valid=1, id_wr_en=1 and flush=0.
  - Otherwise slot 0 loads a bubble (valid=0).
- mem_stall=1 freezes every slot, regardless of flush or fetch_stall.
- fetch_stall=1 with mem_stall=0 advances the slots with a bubble in slot 0.
- flush=1 with mem_stall=0 inserts a bubble in slot 0. Older slots advance normally.
- pend_count is the popcount of the valid bits, registered alongside the slots.
- stall_count increments every cycle send_nop_n=0 and saturates at all-ones.

## Timing
- Reset: all slots invalid, pend_count=0, stall_count=0. send_nop_n=1 unless fetch_stall or mem_stall is asserted.
- send_nop_n and hazard_src are combinational from the current slots and decode inputs, with no added latency.
- Slot update and counter increment take effect at the next clk edge.
- A producer in decode at cycle t reaches slot 0 at t+1 and retires after slot PIPE_DEPTH-1 at t+PIPE_DEPTH. A dependent instruction therefore stalls at most PIPE_DEPTH cycles.
- Reset asserted mid-stall clears everything on that edge; the next cycle sees no hazards.
- Simultaneous flush and hazard: bubble inserted, send_nop_n low, counter increments.

## Configuration
- HAZ_FWD_EN defined: the execute/memory forwarding path exists.
  - A hazard is raised only when slot 0 matches and has is_load=1 (load-use), giving a one-cycle stall.
  - Matches in all other slots are ignored.
- HAZ_FWD_EN undefined: every valid slot match stalls, as described above.

## Structure
- Package hazard_pkg holds:
  - the slot typedef {valid, dst, is_load};
  - the default parameter constants;
  - the function for the pend_count width.
- Sub-module haz_slot_match holds one slot's dual-source compare and is instantiated PIPE_DEPTH times by a generate loop. The top level owns the shift chain, the counter and the NOP logic.

## Test plan
- Reset then idle, id_valid=0 → send_nop_n=1, pend_count=0, stall_count=0.
- Write R3, then immediately read R3 as src A (default build) → send_nop_n low for 3 cycles, hazard_src=01, stall_count=3, then issue.
- Write R3, then mem_stall held 4 cycles on the next instruction reading R5 → slots frozen, pend_count=1 throughout, stall_count=4, no hazard.
- Hazard on R2 with flush the same cycle → slot 0 bubble, pend_count does not grow, send_nop_n low.
- With HAZ_FWD_EN: a load to R4 followed by an add reading R4 → exactly 1 stall cycle; an ALU write to R4 followed by a read → 0 stall cycles.
- Force 2**CNT_W+5 stall cycles (CNT_W=4 override) → stall_count saturates at 15.
